// File: rtl/red_pitaya_pfd_scheduler_pkg.sv
// Shared types for the PFD scheduler: quadrant codes, in-flight tag record,
// default widths and the turn-direction helper.
package pfd_pkg;

  typedef enum logic [1:0] {
    Q_PP = 2'b00,
    Q_PN = 2'b01,
    Q_NP = 2'b10,
    Q_NN = 2'b11
  } quad_t;

  localparam int NCH_DEF        = 4;
  localparam int LPFBITS_DEF    = 24;
  localparam int PHASEWIDTH_DEF = 15;
  localparam int TURNWIDTH_DEF  = 4;
  localparam int SIGNALBITS_DEF = 14;
  localparam int LATENCY_DEF    = 13;

  // Tag fields are sized for the largest supported configuration.
  localparam int CH_MAXW   = 3;
  localparam int TURN_MAXW = 16;

  typedef struct packed {
    logic                 valid;
    logic [CH_MAXW-1:0]   ch;
    logic [TURN_MAXW-1:0] turns;
  } tag_t;

  // 2'b01 = one turn up, 2'b11 = one turn down, 2'b00 = no change.
  function automatic logic [1:0] turn_dir(input logic armed, input quad_t last, input quad_t cur);
    logic [1:0] d;
    if (armed && last == Q_NN && cur == Q_NP) begin
      d = 2'b11;
    end else if (armed && last == Q_NP && cur == Q_NN) begin
      d = 2'b01;
    end else begin
      d = 2'b00;
    end
    return d;
  endfunction

endpackage

// File: rtl/red_pitaya_pfd_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a
// registered pointer that advances past each granted channel.
module red_pitaya_pfd_rr_arbiter
  import pfd_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = $clog2(NCH)
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [NCH-1:0] valid_i,
  output logic [NCH-1:0] grant_o,
  output logic           grant_valid_o,
  output logic [CW-1:0]  grant_idx_o
);

  logic [CW-1:0] rr_r;

  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    s = (s >= NCH) ? s - NCH : s;
    return CW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    grant_o       = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      grant_idx_o   = valid_i[wrap_idx(rr_r, i)] ? wrap_idx(rr_r, i) : grant_idx_o;
      grant_valid_o = grant_valid_o | valid_i[wrap_idx(rr_r, i)];
    end
    for (int c = 0; c < NCH; c++) begin
      grant_o[c] = grant_valid_o && (grant_idx_o == CW'(c));
    end
  end

  // Pointer moves to the channel after the one just served.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_r <= '0;
    end else if (grant_valid_o) begin
      rr_r <= (grant_idx_o == CW'(NCH - 1)) ? '0 : grant_idx_o + CW'(1);
    end
  end

endmodule

// File: rtl/red_pitaya_pfd_scheduler.sv
// Time-shares one pipelined CORDIC among NCH I/Q channels, unwrapping turns
// per channel and reassembling {turns, phase} when each result returns.
module red_pitaya_pfd_scheduler
  import pfd_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int LPFBITS    = LPFBITS_DEF,
  parameter int PHASEWIDTH = PHASEWIDTH_DEF,
  parameter int TURNWIDTH  = TURNWIDTH_DEF,
  parameter int SIGNALBITS = SIGNALBITS_DEF,
  parameter int LATENCY    = LATENCY_DEF
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [NCH-1:0]            req_valid_i,
  output logic [NCH-1:0]            req_ready_o,
  input  logic [NCH*LPFBITS-1:0]    req_i_i,
  input  logic [NCH*LPFBITS-1:0]    req_q_i,
  input  logic [NCH-1:0]            clr_i,
  output logic                      cor_valid_o,
  output logic [LPFBITS-1:0]        cor_i_o,
  output logic [LPFBITS-1:0]        cor_q_o,
  input  logic [PHASEWIDTH-1:0]     cor_phase_i,
  output logic                      out_valid_o,
  output logic [$clog2(NCH)-1:0]    out_ch_o,
  output logic [NCH*SIGNALBITS-1:0] integral_o
);

  localparam int CW = $clog2(NCH);
  localparam int PW = SIGNALBITS - TURNWIDTH;

  logic                  hs_s;
  logic [CW-1:0]         sel_s;
  logic [LPFBITS-1:0]    sel_i_s, sel_q_s;
  logic [TURNWIDTH-1:0]  cur_turns_s, upd_s, snap_s;
  quad_t                 cur_last_s, qd_s;
  logic                  cur_armed_s, cur_clr_s, res_live_s;
  tag_t                  tag_out_s;

  logic [TURNWIDTH-1:0]  turns_r [NCH];
  quad_t                 last_quad_r [NCH];
  logic [NCH-1:0]        armed_r;
  tag_t                  tag_r [LATENCY+1];
  logic [SIGNALBITS-1:0] integral_r [NCH];

  function automatic logic tag_alive(input tag_t t, input logic [NCH-1:0] clr);
    return t.valid && !clr[t.ch[CW-1:0]];
  endfunction

  red_pitaya_pfd_rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .valid_i       (req_valid_i),
    .grant_o       (req_ready_o),
    .grant_valid_o (hs_s),
    .grant_idx_o   (sel_s)
  );

  // Granted channel's sample and state, and its turn count after this sample.
  always_comb begin
    sel_i_s     = '0;
    sel_q_s     = '0;
    cur_turns_s = '0;
    cur_last_s  = Q_NN;
    cur_armed_s = 1'b0;
    cur_clr_s   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      sel_i_s     = (sel_s == CW'(c)) ? req_i_i[c*LPFBITS +: LPFBITS] : sel_i_s;
      sel_q_s     = (sel_s == CW'(c)) ? req_q_i[c*LPFBITS +: LPFBITS] : sel_q_s;
      cur_turns_s = (sel_s == CW'(c)) ? turns_r[c] : cur_turns_s;
      cur_last_s  = (sel_s == CW'(c)) ? last_quad_r[c] : cur_last_s;
      cur_armed_s = (sel_s == CW'(c)) ? armed_r[c] : cur_armed_s;
      cur_clr_s   = (sel_s == CW'(c)) ? clr_i[c] : cur_clr_s;
    end
    qd_s = quad_t'({sel_i_s[LPFBITS-1], sel_q_s[LPFBITS-1]});
    case (turn_dir(cur_armed_s, cur_last_s, qd_s))
      2'b01:   upd_s = cur_turns_s + TURNWIDTH'(1);
      2'b11:   upd_s = cur_turns_s - TURNWIDTH'(1);
      default: upd_s = cur_turns_s;
    endcase
    snap_s = cur_clr_s ? '0 : upd_s;
  end

  // Per-channel turn counter, last quadrant and arming; a same-cycle
  // handshake re-arms even while clear forces the count to zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NCH; c++) begin
        turns_r[c]     <= '0;
        last_quad_r[c] <= Q_NN;
      end
      armed_r <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (hs_s && sel_s == CW'(c)) begin
          turns_r[c]     <= snap_s;
          last_quad_r[c] <= qd_s;
          armed_r[c]     <= 1'b1;
        end else if (clr_i[c]) begin
          turns_r[c] <= '0;
          armed_r[c] <= 1'b0;
        end
      end
    end
  end

  // Tag line tracks the CORDIC latency; clearing a channel drops its tags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int j = 0; j <= LATENCY; j++) begin
        tag_r[j] <= '0;
      end
    end else begin
      tag_r[0] <= '{valid: hs_s, ch: CH_MAXW'(sel_s), turns: TURN_MAXW'(snap_s)};
      for (int j = 1; j <= LATENCY; j++) begin
        tag_r[j]       <= tag_r[j-1];
        tag_r[j].valid <= tag_alive(tag_r[j-1], clr_i);
      end
    end
  end

  assign tag_out_s  = tag_r[LATENCY];
  assign res_live_s = tag_alive(tag_out_s, clr_i);

  // Issue register toward the core and result assembly from the aligned tag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cor_valid_o <= 1'b0;
      cor_i_o     <= '0;
      cor_q_o     <= '0;
      out_valid_o <= 1'b0;
      out_ch_o    <= '0;
      for (int c = 0; c < NCH; c++) begin
        integral_r[c] <= '0;
      end
    end else begin
      cor_valid_o <= hs_s;
      if (hs_s) begin
        cor_i_o <= sel_i_s;
        cor_q_o <= sel_q_s;
      end
      out_valid_o <= res_live_s;
      if (res_live_s) begin
        out_ch_o <= tag_out_s.ch[CW-1:0];
      end
      for (int c = 0; c < NCH; c++) begin
        if (res_live_s && tag_out_s.ch[CW-1:0] == CW'(c)) begin
          integral_r[c] <= {tag_out_s.turns[TURNWIDTH-1:0], cor_phase_i[PHASEWIDTH-1 -: PW]};
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign integral_o[g*SIGNALBITS +: SIGNALBITS] = integral_r[g];
  end

endmodule

// File: tb/tb_red_pitaya_pfd_scheduler.sv
// Bench for red_pitaya_pfd_scheduler: mock fixed-latency core, queue-based
// reference model, arbitration vector table, directed corner cases, random run.
module tb_red_pitaya_pfd_scheduler;

  localparam int NCH = 4, LPF = 24, PHW = 15, TW = 4, SB = 14, L = 13;
  localparam int CW = 2, PW = SB - TW;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NCH-1:0]      req_valid, req_ready, clr;
  logic [NCH*LPF-1:0]  req_i, req_q;
  logic                cor_valid, out_valid;
  logic [LPF-1:0]      cor_i, cor_q;
  logic [PHW-1:0]      cor_phase;
  logic [CW-1:0]       out_ch;
  logic [NCH*SB-1:0]   integral;
  logic signed [LPF-1:0] si [NCH];
  logic signed [LPF-1:0] sq [NCH];
  logic [PHW-1:0]      core_pipe [L];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCH; g++) begin : g_drv
    assign req_i[g*LPF +: LPF] = si[g];
    assign req_q[g*LPF +: LPF] = sq[g];
  end

  red_pitaya_pfd_scheduler #(.NCH(NCH), .LPFBITS(LPF), .PHASEWIDTH(PHW), .TURNWIDTH(TW),
                             .SIGNALBITS(SB), .LATENCY(L)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_i_i(req_i), .req_q_i(req_q), .clr_i(clr), .cor_valid_o(cor_valid),
    .cor_i_o(cor_i), .cor_q_o(cor_q), .cor_phase_i(cor_phase), .out_valid_o(out_valid),
    .out_ch_o(out_ch), .integral_o(integral));

  // Stand-in core: arbitrary deterministic phase of the issued sample, L cycles later.
  function automatic logic [PHW-1:0] mock_phase(input logic [LPF-1:0] i, input logic [LPF-1:0] q);
    logic [LPF-1:0] t;
    t = i * 24'd7 + q * 24'd13;
    return t[PHW-1:0];
  endfunction

  always @(posedge clk) begin
    core_pipe[0] <= mock_phase(cor_i, cor_q);
    for (int j = 1; j < L; j++) core_pipe[j] <= core_pipe[j-1];
  end
  assign cor_phase = core_pipe[L-1];

  // ---------------- reference model ----------------
  typedef struct { int due; int ch; logic [SB-1:0] val; } ev_t;
  ev_t evq[$];
  int  m_rr, m_turns[NCH], m_last[NCH], m_out_ch, edge_no, last_grant;
  bit  m_armed[NCH], m_out_valid, m_cor_valid;
  logic [SB-1:0]  m_integral[NCH];
  logic [LPF-1:0] m_cor_i, m_cor_q;
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wrap_t(input int x);
    int m, r;
    m = 1 << TW;
    r = (x + m / 2) % m;
    if (r < 0) r += m;
    return r - m / 2;
  endfunction

  function automatic int model_grant(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[(m_rr + i) % NCH]) return (m_rr + i) % NCH;
    return -1;
  endfunction

  function automatic logic [NCH*SB-1:0] pack_int();
    logic [NCH*SB-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*SB +: SB] = m_integral[c];
    return r;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_out_valid = 0; m_out_ch = 0; m_cor_valid = 0; m_cor_i = '0; m_cor_q = '0;
    for (int c = 0; c < NCH; c++) begin
      m_turns[c] = 0; m_last[c] = 3; m_armed[c] = 0; m_integral[c] = '0;
    end
    evq.delete();
    last_grant = -1;
  endtask

  task automatic model_edge();
    int g, qd, idx;
    ev_t e;
    logic [TW-1:0]  tt;
    logic [PHW-1:0] ph;
    edge_no++;
    for (int c = 0; c < NCH; c++)
      if (clr[c]) for (int k = evq.size() - 1; k >= 0; k--) if (evq[k].ch == c) evq.delete(k);
    m_out_valid = 0;
    idx = -1;
    foreach (evq[k]) if (evq[k].due == edge_no) idx = k;
    if (idx >= 0) begin
      m_integral[evq[idx].ch] = evq[idx].val;
      m_out_valid = 1;
      m_out_ch = evq[idx].ch;
      evq.delete(idx);
    end
    g = model_grant(req_valid);
    last_grant = g;
    for (int c = 0; c < NCH; c++) if (c != g && clr[c]) begin m_turns[c] = 0; m_armed[c] = 0; end
    if (g >= 0) begin
      qd = (si[g] < 0 ? 2 : 0) + (sq[g] < 0 ? 1 : 0);
      if (clr[g]) m_turns[g] = 0;
      else if (m_armed[g] && m_last[g] == 3 && qd == 2) m_turns[g] = wrap_t(m_turns[g] - 1);
      else if (m_armed[g] && m_last[g] == 2 && qd == 3) m_turns[g] = wrap_t(m_turns[g] + 1);
      m_last[g] = qd;
      m_armed[g] = 1;
      tt = TW'(m_turns[g]);
      ph = mock_phase(si[g], sq[g]);
      e.due = edge_no + 1 + L; e.ch = g; e.val = {tt, ph[PHW-1 -: PW]};
      evq.push_back(e);
      m_rr = (g + 1) % NCH;
      m_cor_valid = 1; m_cor_i = si[g]; m_cor_q = sq[g];
    end else begin
      m_cor_valid = 0;
    end
  endtask

  // One clock: check everything against the model, then advance it at the edge.
  task automatic step();
    logic [NCH-1:0] er;
    int g;
    if (!rstn) model_reset();
    #1;
    g  = model_grant(req_valid);
    er = (g >= 0) ? (NCH'(1) << g) : '0;
    chk("ready", 128'(req_ready), 128'(er));
    chk("cor_valid", 128'(cor_valid), 128'(m_cor_valid));
    chk("cor_i", 128'(cor_i), 128'(m_cor_i));
    chk("cor_q", 128'(cor_q), 128'(m_cor_q));
    chk("out_valid", 128'(out_valid), 128'(m_out_valid));
    chk("out_ch", 128'(out_ch), 128'(m_out_ch));
    chk("integral", 128'(integral), 128'(pack_int()));
    @(posedge clk);
    if (rstn) model_edge();
    @(negedge clk);
  endtask

  task automatic rand_data(input int c);
    si[c] = LPF'($urandom);
    sq[c] = LPF'($urandom);
  endtask

  // qd bit1 = I negative, bit0 = Q negative.
  task automatic set_quad(input int c, input int qd);
    int a, b;
    a = $urandom_range(1, 100000);
    b = $urandom_range(1, 100000);
    si[c] = (qd & 2) ? LPF'(-a) : LPF'(a);
    sq[c] = (qd & 1) ? LPF'(-b) : LPF'(b);
  endtask

  task automatic do_reset();
    req_valid = '0; clr = '0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  typedef struct { logic [NCH-1:0] valid; logic [NCH-1:0] exp_ready; } vec_t;
  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt1, cnt0;
    logic [SB-1:0] keep1;
    rstn = 1'b0; req_valid = '0; clr = '0; edge_no = 0;
    for (int c = 0; c < NCH; c++) begin si[c] = '0; sq[c] = '0; end
    model_reset();
    @(negedge clk);
    step();
    rstn = 1'b1;

    // Arbitration sequence from pointer 0 (hand-derived grants).
    tbl[0]  = '{4'b0000, 4'b0000}; tbl[1]  = '{4'b1111, 4'b0001}; tbl[2]  = '{4'b1111, 4'b0010};
    tbl[3]  = '{4'b0001, 4'b0001}; tbl[4]  = '{4'b1000, 4'b1000}; tbl[5]  = '{4'b0110, 4'b0010};
    tbl[6]  = '{4'b0000, 4'b0000}; tbl[7]  = '{4'b0011, 4'b0001}; tbl[8]  = '{4'b1001, 4'b1000};
    tbl[9]  = '{4'b1111, 4'b0001}; tbl[10] = '{4'b1100, 4'b0100}; tbl[11] = '{4'b0111, 4'b0001};
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid;
      for (int c = 0; c < NCH; c++) rand_data(c);
      #1 chk("tbl_ready", 128'(req_ready), 128'(tbl[i].exp_ready));
      step();
    end
    req_valid = '0;
    repeat (L + 3) step();

    // Quadrant 11 then 10 on channel 0: one turn down, result L+2 after handshake.
    do_reset();
    si[0] = -24'sd1000; sq[0] = -24'sd5; req_valid = 4'b0001; step();
    req_valid = '0; step();
    sq[0] = 24'sd5; req_valid = 4'b0001; step();
    req_valid = '0;
    repeat (L) step();
    #1 chk("turn_dn_early", 128'(out_valid), 128'(1'b0));
    step();
    #1 chk("turn_dn_valid", 128'(out_valid), 128'(1'b1));
    chk("turn_dn_nibble", 128'(integral[SB-1 -: TW]), 128'(4'hF));

    // All channels requesting: strict 0,1,2,3 rotation.
    req_valid = 4'b1111;
    repeat (12) begin for (int c = 0; c < NCH; c++) rand_data(c); step(); end
    req_valid = '0;
    repeat (L + 3) step();

    // Eight full turns up on channel 0 at one sample per cycle: 7 wraps to -8.
    do_reset();
    req_valid = 4'b0001;
    set_quad(0, 2); step();
    for (int k = 0; k < 8; k++) begin
      set_quad(0, 3); step(); set_quad(0, 1); step(); set_quad(0, 0); step(); set_quad(0, 2); step();
    end
    req_valid = '0;
    repeat (L + 2) step();
    #1 chk("wrap_nibble", 128'(integral[SB-1 -: TW]), 128'(4'h8));

    // After a clear the channel is unarmed: 10 -> 11 does not count.
    clr = 4'b0001; step(); clr = '0;
    set_quad(0, 3); req_valid = 4'b0001; step();
    req_valid = '0;
    repeat (L + 2) step();
    #1 chk("unarmed_nibble", 128'(integral[SB-1 -: TW]), 128'(4'h0));

    // Clear channel 1 with three results in flight.
    do_reset();
    set_quad(1, 1); req_valid = 4'b0010; step();
    req_valid = '0;
    repeat (L + 3) step();
    keep1 = m_integral[1];
    req_valid = 4'b0011;
    repeat (6) begin rand_data(0); rand_data(1); step(); end
    req_valid = 4'b0001;
    repeat (2) begin rand_data(0); step(); end
    clr = 4'b0010; rand_data(0); step();
    clr = '0; req_valid = '0;
    cnt0 = 0; cnt1 = 0;
    repeat (L + 3) begin
      step();
      #1;
      if (out_valid && out_ch == 2'd1) cnt1++;
      if (out_valid && out_ch == 2'd0) cnt0++;
    end
    chk("clr_ch1_pulses", 128'(cnt1), 128'(0));
    chk("clr_ch0_pulses", 128'(cnt0), 128'(6));
    chk("clr_int1_held", 128'(integral[SB +: SB]), 128'(keep1));

    // Reset pulse mid-stream.
    req_valid = 4'b1111;
    repeat (6) begin for (int c = 0; c < NCH; c++) rand_data(c); step(); end
    rstn = 1'b0;
    #1 chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_integral", 128'(integral), 128'(0));
    chk("rst_cor_valid", 128'(cor_valid), 128'(1'b0));
    step();
    rstn = 1'b1;
    repeat (L + 6) begin for (int c = 0; c < NCH; c++) rand_data(c); step(); end

    // Random traffic with held requests and occasional clears.
    req_valid = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!req_valid[c] || last_grant == c) begin
          req_valid[c] = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 1) == 0) set_quad(c, $urandom_range(0, 3));
          else rand_data(c);
        end
        clr[c] = ($urandom_range(0, 39) == 0);
      end
      step();
    end
    req_valid = '0; clr = '0;
    repeat (L + 3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
